// File: rtl/base_pkg.sv
// Shared definitions for the base serialize/deserialize blocks.
package base_pkg;

  // Packer/unpacker handshake state: collecting beats vs. presenting a word.
  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } base_state_t;

  // Width needed to hold a beat count of 0..n inclusive.
  function automatic int unsigned cw_of(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/base_agather_slots.sv
// Slot register file for the beat packer: ways slots of width bits, slot 0 in the MSBs.
module base_agather_slots
  import base_pkg::*;
#(
  parameter int unsigned width = 1,
  parameter int unsigned ways  = 2,
  localparam int unsigned cw   = cw_of(ways)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic                   clr,
  input  logic [cw-1:0]          idx,
  input  logic [width-1:0]       wd,
  output logic [width*ways-1:0]  data
);

  // Indexed write; clr zeroes every slot not being written this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
    end else begin
      for (int unsigned i = 0; i < ways; i++) begin
        if (we && idx == cw'(i)) begin
          data[(ways-1-i)*width +: width] <= wd;
        end else if (clr) begin
          data[(ways-1-i)*width +: width] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/base_agather.sv
// Narrow-to-wide beat packer: gathers up to ways beats into one word, i_e closes early.
module base_agather
  import base_pkg::*;
#(
  parameter int unsigned width = 1,
  parameter int unsigned ways  = 2,
  localparam int unsigned cw   = cw_of(ways)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_v,
  output logic                   i_r,
  input  logic [width-1:0]       i_d,
  input  logic                   i_e,
  output logic                   o_v,
  input  logic                   o_r,
  output logic [width*ways-1:0]  o_d,
  output logic [cw-1:0]          o_c,
  output logic                   o_e
);

  base_state_t   state;
  logic [cw-1:0] cnt;
  logic          fire_in;
  logic          slot_clr;
  logic [cw-1:0] slot_idx;

  // In FULL a beat is only accepted when the word leaves the same cycle.
  assign i_r      = !reset && ((state == FILL) || o_r);
  assign fire_in  = i_v && i_r;
  // A beat accepted in FULL starts a new group, so it lands in slot 0.
  assign slot_idx = (state == FULL) ? '0 : cnt;
  assign slot_clr = (state == FULL) && o_r;

  base_agather_slots #(
    .width (width),
    .ways  (ways)
  ) u_slots (
    .clk   (clk),
    .reset (reset),
    .we    (fire_in),
    .clr   (slot_clr),
    .idx   (slot_idx),
    .wd    (i_d),
    .data  (o_d)
  );

  // Group FSM: beat counting, word close and output handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
      cnt   <= '0;
      o_v   <= 1'b0;
      o_c   <= '0;
      o_e   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (fire_in) begin
            if (cnt == cw'(ways - 1) || i_e) begin
              state <= FULL;
              o_v   <= 1'b1;
              o_c   <= cnt + 1'b1;
              o_e   <= i_e;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FULL: begin
          if (o_r) begin
            if (fire_in && i_e) begin
              o_c <= cw'(1);
              o_e <= 1'b1;
            end else if (fire_in) begin
              state <= FILL;
              o_v   <= 1'b0;
              cnt   <= cw'(1);
            end else begin
              state <= FILL;
              o_v   <= 1'b0;
              cnt   <= '0;
            end
          end
        end
        default: begin
          state <= FILL;
          o_v   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_base_agather.sv
// Directed bench for base_agather: ways=2 and ways=4 instances, width=8.
module tb_base_agather;

  logic        clk = 1'b0;
  logic        rst2, rst4;

  logic        i_v2, i_r2, i_e2, o_v2, o_r2, o_e2;
  logic [7:0]  i_d2;
  logic [15:0] o_d2;
  logic [1:0]  o_c2;

  logic        i_v4, i_r4, i_e4, o_v4, o_r4, o_e4;
  logic [7:0]  i_d4;
  logic [31:0] o_d4;
  logic [2:0]  o_c4;

  int n_checks = 0;
  int n_errors = 0;
  int words    = 0;

  always #5 clk = ~clk;

  base_agather #(.width(8), .ways(2)) dut2 (
    .clk(clk), .reset(rst2),
    .i_v(i_v2), .i_r(i_r2), .i_d(i_d2), .i_e(i_e2),
    .o_v(o_v2), .o_r(o_r2), .o_d(o_d2), .o_c(o_c2), .o_e(o_e2)
  );

  base_agather #(.width(8), .ways(4)) dut4 (
    .clk(clk), .reset(rst4),
    .i_v(i_v4), .i_r(i_r4), .i_d(i_d4), .i_e(i_e4),
    .o_v(o_v4), .o_r(o_r4), .o_d(o_d4), .o_c(o_c4), .o_e(o_e4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst2 = 1'b1; rst4 = 1'b1;
    i_v2 = 1'b0; i_d2 = '0; i_e2 = 1'b0; o_r2 = 1'b1;
    i_v4 = 1'b0; i_d4 = '0; i_e4 = 1'b0; o_r4 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ov",  32'(o_v2), 32'd0);
    chk("rst_ir",  32'(i_r2), 32'd0);
    chk("rst_od",  32'(o_d2), 32'd0);
    chk("rst_oc",  32'(o_c2), 32'd0);
    chk("rst_oe",  32'(o_e2), 32'd0);
    chk("rst_ir4", 32'(i_r4), 32'd0);
    rst2 = 1'b0; rst4 = 1'b0;
    #1 chk("ir_after_rst", 32'(i_r2), 32'd1);

    // Test 1: two beats make one full word
    @(negedge clk); i_v2 = 1'b1; i_d2 = 8'hA5; i_e2 = 1'b0;
    @(negedge clk); chk("t1_ov_mid", 32'(o_v2), 32'd0); i_d2 = 8'h3C;
    @(negedge clk); i_v2 = 1'b0;
    chk("t1_ov", 32'(o_v2), 32'd1);
    chk("t1_od", 32'(o_d2), 32'hA53C);
    chk("t1_oc", 32'(o_c2), 32'd2);
    chk("t1_oe", 32'(o_e2), 32'd0);
    @(negedge clk);
    chk("t1_ov_done", 32'(o_v2), 32'd0);
    chk("t1_od_clr",  32'(o_d2), 32'd0);

    // Test 3: 8 beats back to back, no bubbles
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t3_ov", 32'(o_v2), (k >= 2 && k % 2 == 0) ? 32'd1 : 32'd0);
      if (o_v2) begin
        words++;
        chk("t3_od", 32'(o_d2), 32'((k - 1) * 256 + k));
      end
      i_v2 = 1'b1; i_d2 = 8'(k + 1);
      #1 chk("t3_ir", 32'(i_r2), 32'd1);
    end
    @(negedge clk); i_v2 = 1'b0;
    chk("t3_ov_last", 32'(o_v2), 32'd1);
    chk("t3_od_last", 32'(o_d2), 32'h0708);
    if (o_v2) words++;
    chk("t3_words", 32'(words), 32'd4);

    // Test 4: backpressure holds the word and stalls input
    @(negedge clk);
    o_r2 = 1'b0; i_v2 = 1'b1; i_d2 = 8'hAA;
    @(negedge clk); i_d2 = 8'hBB;
    @(negedge clk); i_d2 = 8'hCC;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_ov_hold", 32'(o_v2), 32'd1);
      chk("t4_od_hold", 32'(o_d2), 32'hAABB);
      chk("t4_ir_hold", 32'(i_r2), 32'd0);
      @(negedge clk);
    end
    o_r2 = 1'b1;
    #1 chk("t4_ir_rel", 32'(i_r2), 32'd1);
    chk("t4_od_rel", 32'(o_d2), 32'hAABB);
    @(negedge clk); chk("t4_ov_fill", 32'(o_v2), 32'd0); i_d2 = 8'hDD;
    @(negedge clk); i_v2 = 1'b0;
    chk("t4_ov2", 32'(o_v2), 32'd1);
    chk("t4_od2", 32'(o_d2), 32'hCCDD);
    @(negedge clk); chk("t4_ov_done", 32'(o_v2), 32'd0);

    // Test 2: short group closed by i_e
    @(negedge clk); i_v4 = 1'b1; i_d4 = 8'h11; i_e4 = 1'b0;
    @(negedge clk); i_d4 = 8'h22; i_e4 = 1'b1;
    @(negedge clk);
    chk("t2_ov", 32'(o_v4), 32'd1);
    chk("t2_od", o_d4, 32'h11220000);
    chk("t2_oc", 32'(o_c4), 32'd2);
    chk("t2_oe", 32'(o_e4), 32'd1);
    // Test 5: single-beat group accepted while word leaves
    i_d4 = 8'h77; i_e4 = 1'b1;
    #1 chk("t5_ir", 32'(i_r4), 32'd1);
    @(negedge clk); i_v4 = 1'b0; i_e4 = 1'b0;
    chk("t5_ov", 32'(o_v4), 32'd1);
    chk("t5_od", o_d4, 32'h77000000);
    chk("t5_oc", 32'(o_c4), 32'd1);
    chk("t5_oe", 32'(o_e4), 32'd1);
    @(negedge clk); chk("t5_ov_done", 32'(o_v4), 32'd0);

    // Test 6: reset mid-group discards the partial group
    i_v4 = 1'b1; i_d4 = 8'hAA;
    @(negedge clk); i_d4 = 8'hBB;
    @(negedge clk); i_v4 = 1'b0; rst4 = 1'b1;
    #1;
    chk("t6_ov_rst", 32'(o_v4), 32'd0);
    chk("t6_ir_rst", 32'(i_r4), 32'd0);
    chk("t6_od_rst", o_d4, 32'd0);
    @(negedge clk); rst4 = 1'b0;
    i_v4 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      i_d4 = 8'(k);
      @(negedge clk);
    end
    chk("t6_ov", 32'(o_v4), 32'd1);
    chk("t6_od", o_d4, 32'h01020304);
    chk("t6_oc", 32'(o_c4), 32'd4);
    chk("t6_oe", 32'(o_e4), 32'd0);
    // i_e on the last slot closes a full group with o_e set
    for (int k = 5; k <= 8; k++) begin
      i_d4 = 8'(k); i_e4 = (k == 8);
      @(negedge clk);
    end
    i_v4 = 1'b0; i_e4 = 1'b0;
    chk("t7_ov", 32'(o_v4), 32'd1);
    chk("t7_od", o_d4, 32'h05060708);
    chk("t7_oc", 32'(o_c4), 32'd4);
    chk("t7_oe", 32'(o_e4), 32'd1);
    @(negedge clk); chk("t7_ov_done", 32'(o_v4), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
